// File: rtl/cory_unpack2.sv
// Splits each A-bit input beat into two independently handshaked output fields.
// Optional accepted-beat counter o_cnt is included when CORY_UNPACK2_CNT_EN is defined.
module cory_unpack2 #(
  parameter int N  = 16,
  parameter int Z0 = N,
  parameter int Z1 = N,
  parameter int A  = Z0 + Z1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_a_v,
  input  logic [A-1:0]  i_a_d,
  output logic          o_a_r,
  output logic          o_z0_v,
  output logic [Z0-1:0] o_z0_d,
  input  logic          i_z0_r,
  output logic          o_z1_v,
  output logic [Z1-1:0] o_z1_d,
`ifdef CORY_UNPACK2_CNT_EN
  output logic [15:0]   o_cnt,
`endif
  input  logic          i_z1_r
);

  logic [A-1:0] r_d;
  logic         r_p0;
  logic         r_p1;
  logic         w_a_hs;
  logic         w_z0_hs;
  logic         w_z1_hs;

  // Ready when every still-pending side is being drained this cycle.
  assign o_a_r   = (~r_p0 | i_z0_r) & (~r_p1 | i_z1_r);
  assign w_a_hs  = i_a_v & o_a_r;
  assign w_z0_hs = r_p0 & i_z0_r;
  assign w_z1_hs = r_p1 & i_z1_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d  <= '0;
      r_p0 <= 1'b0;
      r_p1 <= 1'b0;
    end else if (w_a_hs) begin
      r_d  <= i_a_d;
      r_p0 <= 1'b1;
      r_p1 <= 1'b1;
    end else begin
      if (w_z0_hs) r_p0 <= 1'b0;
      if (w_z1_hs) r_p1 <= 1'b0;
    end
  end

  assign o_z0_v = r_p0;
  assign o_z0_d = r_d[Z0-1:0];
  assign o_z1_v = r_p1;
  assign o_z1_d = r_d[A-1:Z0];

`ifdef CORY_UNPACK2_CNT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_a_hs) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_cnt = r_cnt;
`endif

`ifdef SIM
`ifdef CORY_MON
  cory_monitor #(.N(Z0)) u_mon_z0 (
    .clk   (clk),
    .reset (reset),
    .i_v   (o_z0_v),
    .i_d   (o_z0_d),
    .i_r   (i_z0_r)
  );
  cory_monitor #(.N(Z1)) u_mon_z1 (
    .clk   (clk),
    .reset (reset),
    .i_v   (o_z1_v),
    .i_d   (o_z1_d),
    .i_r   (i_z1_r)
  );
`endif
`endif

endmodule

// File: tb/tb_cory_unpack2.sv
// Directed table-driven bench for cory_unpack2 (N=16), plus burst and counter-wrap sequences.
module tb_cory_unpack2;

  logic        clk;
  logic        reset;
  logic        a_v;
  logic [31:0] a_d;
  logic        a_r;
  logic        z0_v;
  logic [15:0] z0_d;
  logic        z0_r;
  logic        z1_v;
  logic [15:0] z1_d;
  logic        z1_r;
`ifdef CORY_UNPACK2_CNT_EN
  logic [15:0] cnt;
`endif

  int checks = 0;
  int errors = 0;

  cory_unpack2 #(.N(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .i_a_v  (a_v),
    .i_a_d  (a_d),
    .o_a_r  (a_r),
    .o_z0_v (z0_v),
    .o_z0_d (z0_d),
    .i_z0_r (z0_r),
    .o_z1_v (z1_v),
    .o_z1_d (z1_d),
`ifdef CORY_UNPACK2_CNT_EN
    .o_cnt  (cnt),
`endif
    .i_z1_r (z1_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        av;
    logic [31:0] ad;
    logic        r0;
    logic        r1;
    logic        e_ar;
    logic        e_v0;
    logic [15:0] e_d0;
    logic        e_v1;
    logic [15:0] e_d1;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tv[21];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic rst, input logic av, input logic [31:0] ad,
                       input logic r0, input logic r1);
    @(negedge clk);
    reset = rst;
    a_v   = av;
    a_d   = ad;
    z0_r  = r0;
    z1_r  = r1;
    #1;
  endtask

  initial begin
    // Observed outputs are the state before the edge that follows each row.
    tv[0]  = '{1, 0, 32'h0,         0, 0, 1, 0, 16'h0,    0, 16'h0,    16'd0};
    tv[1]  = '{0, 1, 32'hBEEF_1234, 1, 1, 1, 0, 16'h0,    0, 16'h0,    16'd0};
    tv[2]  = '{0, 0, 32'h0,         1, 1, 1, 1, 16'h1234, 1, 16'hBEEF, 16'd1};
    tv[3]  = '{0, 0, 32'h0,         1, 1, 1, 0, 16'h1234, 0, 16'hBEEF, 16'd1};
    tv[4]  = '{0, 1, 32'hBEEF_1234, 1, 0, 1, 0, 16'h1234, 0, 16'hBEEF, 16'd1};
    tv[5]  = '{0, 0, 32'h0,         1, 0, 0, 1, 16'h1234, 1, 16'hBEEF, 16'd2};
    tv[6]  = '{0, 0, 32'h0,         1, 0, 0, 0, 16'h1234, 1, 16'hBEEF, 16'd2};
    tv[7]  = '{0, 0, 32'h0,         1, 0, 0, 0, 16'h1234, 1, 16'hBEEF, 16'd2};
    tv[8]  = '{0, 0, 32'h0,         1, 1, 1, 0, 16'h1234, 1, 16'hBEEF, 16'd2};
    tv[9]  = '{0, 0, 32'h0,         1, 1, 1, 0, 16'h1234, 0, 16'hBEEF, 16'd2};
    tv[10] = '{0, 1, 32'hAAAA_5555, 1, 0, 1, 0, 16'h1234, 0, 16'hBEEF, 16'd2};
    tv[11] = '{0, 0, 32'h0,         1, 0, 0, 1, 16'h5555, 1, 16'hAAAA, 16'd3};
    tv[12] = '{0, 1, 32'h0000_0005, 1, 1, 1, 0, 16'h5555, 1, 16'hAAAA, 16'd3};
    tv[13] = '{0, 0, 32'h0,         0, 0, 0, 1, 16'h0005, 1, 16'h0000, 16'd4};
    tv[14] = '{0, 0, 32'hFFFF_FFFF, 1, 1, 1, 1, 16'h0005, 1, 16'h0000, 16'd4};
    tv[15] = '{0, 0, 32'hFFFF_FFFF, 1, 1, 1, 0, 16'h0005, 0, 16'h0000, 16'd4};
    tv[16] = '{0, 1, 32'h1234_5678, 0, 0, 1, 0, 16'h0005, 0, 16'h0000, 16'd4};
    tv[17] = '{1, 1, 32'h9999_9999, 1, 1, 1, 1, 16'h5678, 1, 16'h1234, 16'd5};
    tv[18] = '{0, 0, 32'h0,         0, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'd0};
    tv[19] = '{0, 1, 32'hCAFE_F00D, 1, 1, 1, 0, 16'h0000, 0, 16'h0000, 16'd0};
    tv[20] = '{0, 0, 32'h0,         1, 1, 1, 1, 16'hF00D, 1, 16'hCAFE, 16'd1};

    reset = 1'b1;
    a_v   = 1'b0;
    a_d   = '0;
    z0_r  = 1'b0;
    z1_r  = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 21; i++) begin
      drive(tv[i].rst, tv[i].av, tv[i].ad, tv[i].r0, tv[i].r1);
      check("a_r",  i, {31'b0, a_r},  {31'b0, tv[i].e_ar});
      check("z0_v", i, {31'b0, z0_v}, {31'b0, tv[i].e_v0});
      check("z0_d", i, {16'b0, z0_d}, {16'b0, tv[i].e_d0});
      check("z1_v", i, {31'b0, z1_v}, {31'b0, tv[i].e_v1});
      check("z1_d", i, {16'b0, z1_d}, {16'b0, tv[i].e_d1});
`ifdef CORY_UNPACK2_CNT_EN
      check("cnt",  i, {16'b0, cnt},  {16'b0, tv[i].e_cnt});
`endif
    end

    // 100 back-to-back beats with both sides always ready.
    drive(1, 0, 32'h0, 1, 1);
    for (int c = 0; c <= 100; c++) begin
      logic [15:0] f0;
      f0 = 16'(c);
      drive(0, (c < 100), {f0 + 16'h0100, f0}, 1, 1);
      check("burst_a_r", c, {31'b0, a_r}, 32'd1);
      if (c >= 1) begin
        check("burst_v", c, {30'b0, z1_v, z0_v}, 32'd3);
        check("burst_d", c, {z1_d, z0_d}, {16'(c - 1) + 16'h0100, 16'(c - 1)});
      end else begin
        check("burst_v", c, {30'b0, z1_v, z0_v}, 32'd0);
      end
    end
`ifdef CORY_UNPACK2_CNT_EN
    check("burst_cnt", 0, {16'b0, cnt}, 32'd100);

    // Preload 65535 beats, then one more to wrap the counter.
    drive(1, 0, 32'h0, 1, 1);
    for (int c = 0; c < 65535; c++) drive(0, 1, 32'(c), 1, 1);
    drive(0, 0, 32'h0, 1, 1);
    check("cnt_ffff", 0, {16'b0, cnt}, 32'h0000_FFFF);
    drive(0, 1, 32'h1, 1, 1);
    drive(0, 0, 32'h0, 1, 1);
    check("cnt_wrap", 0, {16'b0, cnt}, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
